// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit controller.
//   Operation encodings, per-class latencies, FSM state type and small
//   decode helpers used by mdu_ctrl and mdu_calc.
//   Optional feature macro: MDU_CANCEL_EN (consumed by mdu_ctrl).
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [3:0] MULT_LAT = 4'd5;
   localparam logic [3:0] DIV_LAT  = 4'd10;

   typedef logic [0:0] state_t;

   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_RUN  = 1'b1;

   // op[1] selects the divider, op[0] selects the unsigned variant
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic [3:0] op_lat(input logic [1:0] op);
      return op[1] ? DIV_LAT : MULT_LAT;
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc -- combinational arithmetic for the multiply/divide unit.
//   Works on the operands latched by mdu_ctrl and produces the {hi,lo}
//   result that is committed when the latency counter expires.
// Ports:
//   op     in   2  operation (mult, multu, div, divu)
//   src_a  in  32  latched rs operand
//   src_b  in  32  latched rt operand
//   result out 64  {hi,lo}: product, or {remainder,quotient}
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [63:0] result
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] prod_mag;
   logic [63:0] prod;
   logic        div_zero;
   logic [31:0] dvsr;
   logic [31:0] quot_mag;
   logic [31:0] rem_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   // Signed operations are done on magnitudes and the sign is reapplied.
   // The magnitude of 32'h8000_0000 is representable as an unsigned value,
   // so the 8000_0000 / -1 overflow case falls out naturally as
   // quotient 8000_0000, remainder 0.
   always_comb begin
      neg_a    = op_is_signed(op) & src_a[31];
      neg_b    = op_is_signed(op) & src_b[31];
      mag_a    = neg_a ? -src_a : src_a;
      mag_b    = neg_b ? -src_b : src_b;

      prod_mag = {32'd0, mag_a} * {32'd0, mag_b};
      prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;

      // divisor forced to 1 on zero so the divider never sees /0;
      // the result is overridden below anyway
      div_zero = (src_b == 32'd0);
      dvsr     = div_zero ? 32'd1 : mag_b;
      quot_mag = mag_a / dvsr;
      rem_mag  = mag_a % dvsr;
      quot     = (neg_a ^ neg_b) ? -quot_mag : quot_mag;
      rem      = neg_a ? -rem_mag : rem_mag;

      if (!op_is_div(op)) begin
         result = prod;
      end else if (div_zero) begin
         result = {src_a, 32'hFFFF_FFFF};
      end else begin
         result = {rem, quot};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with architectural HI/LO.
//   Accepts an E-stage mult/multu/div/divu issue, runs a fixed-latency
//   down-counter (5 for multiplies, 10 for divides) and commits the result
//   of mdu_calc to HI/LO when the counter expires. Also handles mthi/mtlo
//   writes and the D-stage stall request for HI/LO users.
// Optional feature macro: MDU_CANCEL_EN adds a cancel (exception flush)
//   input that abandons a running operation and drops same-cycle issues
//   and mthi/mtlo writes.
// Ports:
//   clk          in   1  clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   cancel       in   1  flush (only with MDU_CANCEL_EN)
//   start        in   1  issue strobe
//   op           in   2  operation encoding (mdu_pkg OP_*)
//   src_a, src_b in  32  operands, sampled on an accepted start
//   mthi, mtlo   in   1  HI / LO write strobes
//   wdata        in  32  data for mthi/mtlo
//   uses_hilo_d  in   1  D-stage instruction touches HI/LO
//   busy         out  1  operation in progress
//   stall        out  1  D-stage stall request
//   done         out  1  one-cycle pulse after HI/LO commit
//   hi, lo       out 32  architectural HI/LO
//
// state  | meaning
// S_IDLE | no operation; accepts start, mthi and mtlo
// S_RUN  | operation in flight; cnt counts down to the commit edge
module mdu_ctrl
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        uses_hilo_d,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] result;
   logic        flush;

`ifdef MDU_CANCEL_EN
   assign flush = cancel;
`else
   assign flush = 1'b0;
`endif

   mdu_calc u_calc (
      .op     (op_q),
      .src_a  (a_q),
      .src_b  (b_q),
      .result (result)
   );

   // busy is a decode of the state register, so it carries no
   // combinational path from the inputs
   assign busy  = (state == S_RUN);
   assign stall = uses_hilo_d & (start | busy);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         op_q  <= 2'b00;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         done  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (flush) begin
               state <= S_IDLE;
            end else if (start) begin
               // start wins over a coincident mthi/mtlo
               op_q  <= op;
               a_q   <= src_a;
               b_q   <= src_b;
               cnt   <= op_lat(op) - 4'd1;
               state <= S_RUN;
            end else begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
            end
         end else begin
            if (flush) begin
               cnt   <= 4'd0;
               state <= S_IDLE;
            end else if (cnt == 4'd0) begin
               hi    <= result[63:32];
               lo    <= result[31:0];
               done  <= 1'b1;
               state <= S_IDLE;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  E-stage mult/multu/div/divu issue strobe.
REQ-004 SHALL have port: op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have ports: src_a, src_b  input  32 each  rs and rt operands, sampled on the accepted start.
REQ-006 SHALL have ports: mthi, mtlo  input  1 each  E-stage HI or LO write strobe.
REQ-007 SHALL have port: wdata  input  32  data for mthi/mtlo.
REQ-008 SHALL have port: uses_hilo_d  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have port: busy  output  1  operation in progress (registered).
REQ-010 SHALL have port: stall  output  1  D-stage stall request (combinational).
REQ-011 SHALL have port: done  output  1  one-cycle pulse on HI/LO commit.
REQ-012 SHALL have ports: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL implement states IDLE and RUN plus a 4-bit down-counter cnt.
REQ-014 IDLE with start=1: latch op/src_a/src_b, load cnt=LAT-1 (LAT: 5 mult/multu, 10 div/divu), enter RUN; busy=1 from the next cycle.
REQ-015 RUN: cnt decrements each cycle; at cnt==0, write HI/LO, assert done for that edge's following cycle, return to IDLE, busy=0.
REQ-016 busy SHALL be high for exactly LAT cycles per operation; back-to-back start SHALL be accepted the cycle busy falls.
REQ-017 hi/lo SHALL hold old values throughout RUN; the new result becomes visible only on commit.
REQ-018 stall SHALL equal uses_hilo_d & (start | busy).
REQ-019 start while in RUN SHALL be ignored.
REQ-020 mthi/mtlo in IDLE SHALL write wdata to HI/LO at the next edge; both asserted together write both.
REQ-021 mthi/mtlo in RUN SHALL be ignored.
REQ-022 When start and mthi/mtlo coincide, start SHALL win and the writes SHALL be dropped.
REQ-023 mult/multu: {hi,lo} SHALL be the 64-bit signed/unsigned product.
REQ-024 div/divu: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder, carrying the dividend's sign.
REQ-025 Divide by zero: lo=32'hFFFF_FFFF, hi=src_a.
REQ-026 Signed 32'h8000_0000 / -1: lo=32'h8000_0000, hi=0.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, cnt=0, busy=0, done=0, hi=0, lo=0.
REQ-028 Reset during RUN SHALL abandon the operation with no commit and no done.

Configuration
REQ-029 Macro MDU_CANCEL_EN defined: add input cancel (1 bit, exception flush).
REQ-030 With MDU_CANCEL_EN, cancel in RUN SHALL return to IDLE next edge with hi/lo unchanged and no done.
REQ-031 With MDU_CANCEL_EN, cancel coincident with start SHALL suppress the start; cancel in IDLE SHALL also drop mthi/mtlo.
REQ-032 Without MDU_CANCEL_EN, there SHALL be no cancel port and every accepted operation SHALL complete.

Structure
REQ-033 Shared package mdu_pkg SHALL hold op encodings, MULT_LAT=5, DIV_LAT=10, state typedef.
REQ-034 Arithmetic SHALL live in sub-module mdu_calc (combinational, latched operands -> 64-bit result); mdu_ctrl owns FSM, counter, HI/LO.

Verification
REQ-035 mult src_a=-3, src_b=7 -> busy 5 cycles, done once, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-036 div src_a=-7, src_b=2 -> busy 10 cycles, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; divu 7/0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-037 uses_hilo_d=1 during mult -> stall high on the start cycle plus 5 busy cycles, low on the 7th.
REQ-038 mthi wdata=32'h1234 coincident with start -> HI is not written; mtlo in IDLE -> lo=wdata next cycle.
REQ-039 reset_n low at cycle 3 of div -> busy=0, hi=lo=0, no done pulse.
REQ-040 MDU_CANCEL_EN: cancel at cycle 2 of mult with hi=5 -> IDLE next cycle, hi=5, no done.
